// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory subordinate.
package imem_pkg;

    typedef enum logic [1:0] {ST_CLEAR, ST_LOAD, ST_RUN} imem_state_t;

    localparam logic [31:0] RV_NOP = 32'h00000013;

endpackage

// File: rtl/ibus_if.sv
// Instruction bus: manager presents a byte address, subordinate returns a registered word.
interface ibus_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [DATA_WIDTH-1:0] rdata;

    modport sub (input araddr, output rdata);
    modport mgr (output araddr, input rdata);
endinterface

// File: rtl/imem_ram.sv
// Simple dual-port word RAM, synchronous read-first, no array reset so it maps onto block RAM.
module imem_ram #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                           clk_i,
    input  logic                           we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]          wdata_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0]          rdata_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_sub.sv
// Instruction-memory subordinate: boot sequence (clear, load, run) plus one-cycle fetch path.
module imem_sub
    import imem_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH  = 32,
    parameter int unsigned          DATA_WIDTH  = 32,
    parameter int unsigned          DEPTH_WORDS = 4096,
    parameter logic [DATA_WIDTH-1:0] NOP_INSN   = RV_NOP
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    ibus_if.sub                          ibus,
    input  logic                         load_valid_i,
    output logic                         load_ready_o,
    input  logic [$clog2(DEPTH_WORDS):0] load_addr_i,
    input  logic [DATA_WIDTH-1:0]        load_data_i,
    input  logic                         load_done_i,
    output logic                         run_o,
    output logic                         load_err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    imem_state_t            state_q, state_d;
    logic [IDX_W-1:0]       cnt_q, cnt_d;
    logic                   ready_q, ready_d;
    logic                   run_q, run_d;
    logic                   err_q, err_d;
    logic                   nop_sel_q, nop_sel_d;

    logic                   ram_we;
    logic [IDX_W-1:0]       ram_waddr;
    logic [DATA_WIDTH-1:0]  ram_wdata;
    logic [IDX_W-1:0]       ram_raddr;
    logic [DATA_WIDTH-1:0]  ram_rdata;
    logic [ADDR_WIDTH-1:0]  araddr_w;
    logic                   rd_out_of_range;

    assign araddr_w        = ibus.araddr;
    assign ram_raddr       = araddr_w[IDX_W+1:2];
    assign rd_out_of_range = (araddr_w >> (IDX_W + 2)) != '0;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        run_d     = run_q;
        err_d     = err_q;
        ram_we    = 1'b0;
        ram_waddr = cnt_q;
        ram_wdata = NOP_INSN;
        // The override flag is registered alongside the RAM read so both line up with the same edge.
        nop_sel_d = (state_q != ST_RUN) || rd_out_of_range;

        case (state_q)
            ST_CLEAR: begin
                ram_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = ST_LOAD;
                    ready_d = 1'b1;
                end
            end
            ST_LOAD: begin
                if (load_valid_i && ready_q) begin
                    if (load_addr_i[IDX_W]) begin
                        err_d = 1'b1;
                    end else begin
                        ram_we    = 1'b1;
                        ram_waddr = load_addr_i[IDX_W-1:0];
                        ram_wdata = load_data_i;
                    end
                end
                if (load_done_i) begin
                    state_d = ST_RUN;
                    ready_d = 1'b0;
                    run_d   = 1'b1;
                end
            end
            ST_RUN: begin
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
                ready_d = 1'b0;
                run_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            run_q     <= 1'b0;
            err_q     <= 1'b0;
            nop_sel_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            run_q     <= run_d;
            err_q     <= err_d;
            nop_sel_q <= nop_sel_d;
        end
    end

    imem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign ibus.rdata   = nop_sel_q ? NOP_INSN : ram_rdata;
    assign load_ready_o = ready_q;
    assign run_o        = run_q;
    assign load_err_o   = err_q;

endmodule
